// File: rtl/mdio_tlp_decoder.sv
// rtl/mdio_tlp_decoder.sv - TRN RX sniffer turning MDIO-register MWr TLPs into stretched acc_en commands
module mdio_tlp_decoder #(
  parameter int          BAR_NUM      = 0,
  parameter int          BAR_APERTURE = 10,
  parameter logic [31:0] MDIO_OFFSET  = 32'h020,
  parameter int          EN_STRETCH   = 8
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic [63:0] trn_rd,
  input  logic [7:0]  trn_rrem_n,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rdst_rdy_n,
  input  logic [6:0]  trn_rbar_hit_n,
  output logic [31:0] acc_data,
  output logic        acc_en,
  output logic        acc_overrun
);

  // Counter holds EN_STRETCH+1 after a capture: one idle cycle before acc_en rises,
  // then EN_STRETCH high cycles. Nonzero means a new hit must be dropped.
  localparam int            CW   = $clog2(EN_STRETCH + 2);
  localparam logic [CW-1:0] LOAD = CW'(EN_STRETCH + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    H3   = 5'b00010,
    H4   = 5'b00100,
    D4   = 5'b01000,
    SKIP = 5'b10000
  } state_t;

  state_t                  state;
  logic [1:0]              rst_pipe;
  logic                    rst_n;
  logic [CW-1:0]           cnt;
  logic [BAR_APERTURE-1:2] addr_q;

  logic                    beat;
  logic                    sof_beat;
  logic                    hdr_match;
  logic                    cap_valid;
  logic [BAR_APERTURE-1:2] cap_off;
  logic [31:0]             cap_data;
  logic                    hit;
  logic [31:0]             cmd;
  logic                    unused_inputs;

  // Remainder and the other BAR-hit bits carry nothing this decoder needs.
  assign unused_inputs = ^{trn_rrem_n, trn_rbar_hit_n};

  // Reset asserts asynchronously and releases two clocks later, synchronous to trn_clk.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  assign beat     = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
  assign sof_beat = beat && !trn_rsof_n;

  // Single-DW, full-BE memory write (3DW or 4DW header) aimed at our BAR.
  assign hdr_match = trn_rd[62]
                  && (trn_rd[60:56] == 5'd0)
                  && (trn_rd[41:32] == 10'd1)
                  && (trn_rd[3:0]   == 4'hF)
                  && !trn_rbar_hit_n[BAR_NUM];

  // Select address offset and payload for the beat that completes a decoded write.
  always_comb begin
    cap_valid = 1'b0;
    cap_off   = '0;
    cap_data  = '0;
    if (beat && trn_rsof_n) begin
      case (state)
        H3: begin
          cap_valid = 1'b1;
          cap_off   = trn_rd[32+BAR_APERTURE-1:34];
          cap_data  = trn_rd[31:0];
        end
        D4: begin
          cap_valid = 1'b1;
          cap_off   = addr_q;
          cap_data  = trn_rd[63:32];
        end
        default: begin
          cap_valid = 1'b0;
        end
      endcase
    end
  end

  assign hit = cap_valid && (cap_off == MDIO_OFFSET[BAR_APERTURE-1:2]);

  // TLP payload is byte 0 first on the wire; the MDIO command wants it little-endian.
  assign cmd = {cap_data[7:0], cap_data[15:8], cap_data[23:16], cap_data[31:24]};

  // Header FSM, command capture, acc_en stretch and sticky overrun flag.
  always_ff @(posedge trn_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      cnt         <= '0;
      acc_data    <= '0;
      acc_en      <= 1'b0;
      acc_overrun <= 1'b0;
    end else begin
      if (cnt != '0) cnt <= cnt - ONE;
      acc_en <= (cnt > ONE);

      if (hit) begin
        if (cnt == '0) begin
          acc_data <= cmd;
          cnt      <= LOAD;
        end else begin
          acc_overrun <= 1'b1;
        end
      end

      if (sof_beat) begin
        if (hdr_match)        state <= trn_rd[61] ? H4 : H3;
        else if (trn_reof_n)  state <= SKIP;
        else                  state <= IDLE;
      end else if (beat) begin
        case (state)
          H3:      state <= IDLE;
          H4: begin
            addr_q <= trn_rd[BAR_APERTURE-1:2];
            state  <= D4;
          end
          D4:      state <= IDLE;
          SKIP:    if (!trn_reof_n) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_tlp_decoder.sv
// tb/tb_mdio_tlp_decoder.sv - directed self-checking bench for mdio_tlp_decoder
module tb_mdio_tlp_decoder;

  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] trn_rd = '0;
  logic [7:0]  trn_rrem_n = 8'h00;
  logic        trn_rsof_n = 1'b1;
  logic        trn_reof_n = 1'b1;
  logic        trn_rsrc_rdy_n = 1'b1;
  logic        trn_rdst_rdy_n = 1'b0;
  logic [6:0]  trn_rbar_hit_n = 7'h7F;
  logic [31:0] acc_data;
  logic        acc_en;
  logic        acc_overrun;

  int checks = 0;
  int failures = 0;
  int first_hi;
  int width;

  localparam logic [6:0] BAR0 = 7'b1111110;
  localparam logic [6:0] BAR1 = 7'b1111101;

  mdio_tlp_decoder dut (
    .trn_clk        (trn_clk),
    .reset_n        (reset_n),
    .trn_rd         (trn_rd),
    .trn_rrem_n     (trn_rrem_n),
    .trn_rsof_n     (trn_rsof_n),
    .trn_reof_n     (trn_reof_n),
    .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
    .trn_rdst_rdy_n (trn_rdst_rdy_n),
    .trn_rbar_hit_n (trn_rbar_hit_n),
    .acc_data       (acc_data),
    .acc_en         (acc_en),
    .acc_overrun    (acc_overrun)
  );

  always #5 trn_clk = ~trn_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Non-beat cycles carry junk, including a false sof, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      trn_rsrc_rdy_n = 1'b1;
      trn_rd         = {$urandom, $urandom};
      trn_rsof_n     = 1'b0;
      trn_reof_n     = 1'b0;
      trn_rbar_hit_n = BAR0;
      @(posedge trn_clk); #1;
    end
    trn_rsof_n = 1'b1;
    trn_reof_n = 1'b1;
  endtask

  task automatic beat(input logic [63:0] d, input logic sof, input logic eof,
                      input logic [7:0] rem, input logic [6:0] bar);
    trn_rd         = d;
    trn_rsof_n     = !sof;
    trn_reof_n     = !eof;
    trn_rrem_n     = rem;
    trn_rbar_hit_n = bar;
    trn_rsrc_rdy_n = 1'b0;
    @(posedge trn_clk); #1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
  endtask

  task automatic mwr3(input logic [31:0] addr, input logic [31:0] data,
                      input logic [6:0] bar, input int gap);
    beat({32'h4000_0001, 32'h0000_000F}, 1'b1, 1'b0, 8'h00, bar);
    if (gap > 0) idle(gap);
    beat({addr, data}, 1'b0, 1'b1, 8'h00, 7'h7F);
  endtask

  task automatic mwr4(input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] data);
    beat({32'h6000_0001, 32'h0000_000F}, 1'b1, 1'b0, 8'h00, BAR0);
    beat({hi, lo}, 1'b0, 1'b0, 8'h00, 7'h7F);
    beat({data, 32'h0}, 1'b0, 1'b1, 8'h0F, 7'h7F);
  endtask

  // Bounded observation window: index of first high cycle and number of high cycles.
  task automatic measure(output int first, output int w);
    first = -1;
    w = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge trn_clk); #1;
      if (acc_en) begin
        if (first < 0) first = i;
        w++;
      end
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge trn_clk);
    #1;
    check("rst_data", acc_data, 0);
    check("rst_en", acc_en, 0);
    check("rst_ovr", acc_overrun, 0);
    reset_n = 1'b1;
    idle(3);

    // 3DW MWr to MDIO register
    mwr3(32'h0000_0020, 32'h0012_030C, BAR0, 0);
    check("t1_data", acc_data, 32'h0C03_1200);
    check("t1_en_capture", acc_en, 0);
    measure(first_hi, width);
    check("t1_first", first_hi, 1);
    check("t1_width", width, 8);

    // 4DW MWr, upper address dword ignored
    mwr4(32'h0000_0001, 32'h0000_0020, 32'h1122_3344);
    check("t2_data", acc_data, 32'h4433_2211);
    measure(first_hi, width);
    check("t2_first", first_hi, 1);
    check("t2_width", width, 8);

    // wrong offset
    mwr3(32'h0000_0024, 32'hDEAD_BEEF, BAR0, 0);
    measure(first_hi, width);
    check("t3_off_width", width, 0);
    // length 2
    beat({32'h4000_0002, 32'h0000_00FF}, 1'b1, 1'b0, 8'h00, BAR0);
    beat({32'h0000_0020, 32'h0102_0304}, 1'b0, 1'b0, 8'h00, 7'h7F);
    beat({32'h0506_0708, 32'h0}, 1'b0, 1'b1, 8'h0F, 7'h7F);
    measure(first_hi, width);
    check("t3_len2_width", width, 0);
    // memory read
    beat({32'h0000_0001, 32'h0000_000F}, 1'b1, 1'b0, 8'h00, BAR0);
    beat({32'h0000_0020, 32'h0}, 1'b0, 1'b1, 8'h0F, 7'h7F);
    measure(first_hi, width);
    check("t3_mrd_width", width, 0);
    // BAR1 hit
    mwr3(32'h0000_0020, 32'h9999_9999, BAR1, 0);
    measure(first_hi, width);
    check("t3_bar1_width", width, 0);
    check("t3_data", acc_data, 32'h4433_2211);
    check("t3_ovr", acc_overrun, 0);

    // two hits three cycles apart
    mwr3(32'h0000_0020, 32'hA1B2_C3D4, BAR0, 0);
    idle(1);
    mwr3(32'h0000_0020, 32'h5566_7788, BAR0, 0);
    check("t4_data", acc_data, 32'hD4C3_B2A1);
    check("t4_ovr", acc_overrun, 1);
    check("t4_en", acc_en, 1);
    measure(first_hi, width);
    check("t4_tail_width", width, 5);

    // hit on the last stretch cycle is dropped, next one after it is taken
    mwr3(32'h0000_0020, 32'h0102_0304, BAR0, 0);
    idle(7);
    mwr3(32'h0000_0020, 32'hFFEE_DDCC, BAR0, 0);
    check("t5_last_data", acc_data, 32'h0403_0201);
    check("t5_last_en", acc_en, 0);
    mwr3(32'h0000_0020, 32'h1020_3040, BAR0, 0);
    check("t5_next_data", acc_data, 32'h4030_2010);
    measure(first_hi, width);
    check("t5_next_width", width, 8);

    // source stalls between header and data
    mwr3(32'h0000_0020, 32'hCAFE_F00D, BAR0, 5);
    check("t6_data", acc_data, 32'h0DF0_FECA);
    measure(first_hi, width);
    check("t6_first", first_hi, 1);
    check("t6_width", width, 8);

    // reset during the stretch
    mwr3(32'h0000_0020, 32'h0012_030C, BAR0, 0);
    idle(3);
    check("t7_en_before", acc_en, 1);
    reset_n = 1'b0;
    #1;
    check("t7_rst_data", acc_data, 0);
    check("t7_rst_en", acc_en, 0);
    check("t7_rst_ovr", acc_overrun, 0);
    idle(2);
    reset_n = 1'b1;
    idle(3);
    mwr3(32'h0000_0020, 32'h8899_AABB, BAR0, 0);
    check("t7_post_data", acc_data, 32'hBBAA_9988);
    measure(first_hi, width);
    check("t7_post_width", width, 8);

    // reset between header and data: the orphan data beat is ignored
    beat({32'h4000_0001, 32'h0000_000F}, 1'b1, 1'b0, 8'h00, BAR0);
    reset_n = 1'b0;
    #1;
    idle(1);
    reset_n = 1'b1;
    idle(3);
    beat({32'h0000_0020, 32'h1357_9BDF}, 1'b0, 1'b1, 8'h00, 7'h7F);
    measure(first_hi, width);
    check("t8_width", width, 0);
    check("t8_data", acc_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
